s2_frame_receiver: RTL and testbench
====================================

// Module: s2_frame_receiver
// PURPOSE
// Receiving end of the sen/sd serial frame link. Deserializes active-low-framed
// serial frames into address + data fields and writes each complete word into
// register bank 2 (RB2). Sits opposite the RB1 frame transmitter, which updates
// sen/sd on the falling clock edge. This block samples on the rising edge, mid-bit.
// Asserts done once FRAMES valid words have been written.
// PARAMETERS
// ADDR_W   3    address field bits per frame, sent MSB first; also RB2_A width
// DATA_W   18   data field bits per frame, sent MSB first; also RB2_D width
// FRAMES   8    valid frames to write before done is asserted
// PORTS
// clk        in   1       system clock; all logic on posedge
// rst        in   1       reset, asynchronous, active-high
// sen        in   1       serial enable, active low; low = frame in progress
// sd         in   1       serial data, valid while sen==0
// RB2_RW     out  1       RB2 read/write: 1 = read (idle), 0 = write strobe
// RB2_A      out  ADDR_W  RB2 write address
// RB2_D      out  DATA_W  RB2 write data
// frame_err  out  1       1-cycle pulse: a malformed frame was discarded
// done       out  1       FRAMES valid writes completed; sticky until rst
// BEHAVIOUR
// - Reset: RB2_RW=1, RB2_A=0, RB2_D=0, frame_err=0, done=0, state=IDLE,
//   bit/frame counters=0, shift regs=0. rst mid-frame aborts the frame; no write.
// - All outputs registered. Each bit is sampled at posedge while sen==0.
// - States:
//   IDLE: sen==1 -> stay. sen==0 -> shift sd into addr_sr, bitcnt=1, go to ADDR.
//   ADDR: sen==0 -> shift into addr_sr. Go to DATA after ADDR_W bits.
//   DATA: sen==0 -> shift into data_sr; bitcnt counts up to ADDR_W+DATA_W.
//         Bits beyond that are ignored but set an overrun flag.
//   DONE: terminal; sen/sd ignored until rst.
// - Frame end: in ADDR or DATA, first posedge with sen==1.
//   - bitcnt==ADDR_W+DATA_W and no overrun -> next cycle RB2_RW=0 for exactly
//     1 cycle, RB2_A=addr_sr, RB2_D=data_sr; frame count +1. State -> IDLE,
//     or -> DONE if count reaches FRAMES.
//   - Otherwise (short or overrun) -> no write, frame_err=1 for 1 cycle,
//     frame count unchanged, state -> IDLE.
// - Back-to-back frames: the gap between frames can be one cycle of sen==1.
//   The write pulse overlaps the first bit of the next frame, which must be
//   captured correctly. Shift regs are reloaded from that first bit.
// - RB2_A/RB2_D hold their last written values between writes.
// - done goes to 1 in the same cycle as the final write pulse, then holds.
//   Once done, later frames produce no writes and no frame_err.
// - Duplicate addresses are not filtered: a later frame overwrites, and both
//   frames count toward FRAMES.
// - bitcnt width is clog2(ADDR_W+DATA_W+1) and saturates. Frame counter width
//   is clog2(FRAMES+1).
// TESTING
// 1 Single frame: addr 3'b101, data 18'h2A5A5 (21 bits), 1 cycle sen high ->
//   RB2_RW=0 for exactly 1 cycle with RB2_A=5, RB2_D=18'h2A5A5; frame_err=0.
// 2 Eight back-to-back frames, 1-cycle gaps, addresses 0..7, data = {addr,15'h7FFF}
//   -> 8 write pulses with matching A/D; done rises with the 8th pulse.
// 3 Short frame: sen low for 10 bits, then high -> frame_err pulse, no write,
//   done still needs 8 valid frames.
// 4 Overrun frame: 23 bits -> frame_err pulse, no write. Next good frame
//   (addr 2, data 18'h00001) writes correctly.
// 5 Reset mid-frame: assert rst after 12 bits -> outputs at reset values, no write.
//   A full good frame afterwards writes normally.
// 6 After done: send a good frame (addr 0, data 18'h3FFFF) -> RB2_RW stays 1,
//   frame_err stays 0, done stays 1.

Source files
------------

// File: rtl/s2_frame_receiver.sv
// Serial frame receiver: deserializes active-low sen/sd frames into address + data
// and issues a one-cycle RB2 write strobe per well-formed frame until FRAMES are written.
module s2_frame_receiver #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 18,
  parameter int FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sen,
  input  logic              sd,
  output logic              RB2_RW,
  output logic [ADDR_W-1:0] RB2_A,
  output logic [DATA_W-1:0] RB2_D,
  output logic              frame_err,
  output logic              done
);

  localparam int TOT = ADDR_W + DATA_W;
  localparam int BW  = $clog2(TOT + 1);
  localparam int FW  = $clog2(FRAMES + 1);

  localparam logic [BW-1:0] ONE_B  = BW'(1);
  localparam logic [BW-1:0] ADDR_C = BW'(ADDR_W);
  localparam logic [BW-1:0] TOT_C  = BW'(TOT);
  localparam logic [FW-1:0] ONE_F  = FW'(1);
  localparam logic [FW-1:0] LAST_F = FW'(FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [BW-1:0]      r_bitcnt, w_bitcnt_nx;
  logic [ADDR_W-1:0]  r_addr_sr, w_addr_nx;
  logic [DATA_W-1:0]  r_data_sr, w_data_nx;
  logic               r_ovr, w_ovr_nx;
  logic [FW-1:0]      r_frmcnt, w_frmcnt_nx;
  logic               r_rw, w_rw_nx;
  logic [ADDR_W-1:0]  r_a, w_a_nx;
  logic [DATA_W-1:0]  r_d, w_d_nx;
  logic               r_err, w_err_nx;
  logic               r_done, w_done_nx;
  logic               w_good;
  logic               w_last;

  // A frame is good only if it ended in DATA with exactly TOT bits and no extras.
  assign w_good = (r_state == S_DATA) && (r_bitcnt == TOT_C) && !r_ovr;
  assign w_last = (r_frmcnt == LAST_F);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (!sen) begin
          w_state_nx = (ADDR_W == 1) ? S_DATA : S_ADDR;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ADDR: begin
        if (sen) begin
          w_state_nx = S_IDLE;
        end else if ((r_bitcnt + ONE_B) == ADDR_C) begin
          w_state_nx = S_DATA;
        end else begin
          w_state_nx = S_ADDR;
        end
      end
      S_DATA: begin
        if (!sen) begin
          w_state_nx = S_DATA;
        end else if (w_good && w_last) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_DONE:  w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_bitcnt_nx = r_bitcnt;
    w_addr_nx   = r_addr_sr;
    w_data_nx   = r_data_sr;
    w_ovr_nx    = r_ovr;
    w_frmcnt_nx = r_frmcnt;
    w_rw_nx     = 1'b1;
    w_a_nx      = r_a;
    w_d_nx      = r_d;
    w_err_nx    = 1'b0;
    w_done_nx   = r_done;
    case (r_state)
      S_IDLE: begin
        if (!sen) begin
          // First bit reloads the shifters, even while a write strobe is still out.
          w_addr_nx    = '0;
          w_addr_nx[0] = sd;
          w_data_nx    = '0;
          w_bitcnt_nx  = ONE_B;
          w_ovr_nx     = 1'b0;
        end else begin
          w_bitcnt_nx = r_bitcnt;
        end
      end
      S_ADDR: begin
        if (!sen) begin
          w_addr_nx    = r_addr_sr << 1;
          w_addr_nx[0] = sd;
          w_bitcnt_nx  = r_bitcnt + ONE_B;
        end else begin
          w_err_nx = 1'b1;
        end
      end
      S_DATA: begin
        if (!sen) begin
          if (r_bitcnt < TOT_C) begin
            w_data_nx    = r_data_sr << 1;
            w_data_nx[0] = sd;
            w_bitcnt_nx  = r_bitcnt + ONE_B;
          end else begin
            w_ovr_nx = 1'b1;
          end
        end else if (w_good) begin
          w_rw_nx     = 1'b0;
          w_a_nx      = r_addr_sr;
          w_d_nx      = r_data_sr;
          w_frmcnt_nx = r_frmcnt + ONE_F;
          if (w_last) begin
            w_done_nx = 1'b1;
          end else begin
            w_done_nx = r_done;
          end
        end else begin
          w_err_nx = 1'b1;
        end
      end
      S_DONE: begin
        w_rw_nx = 1'b1;
      end
      default: begin
        w_rw_nx = 1'b1;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt  <= '0;
      r_addr_sr <= '0;
      r_data_sr <= '0;
      r_ovr     <= 1'b0;
      r_frmcnt  <= '0;
      r_rw      <= 1'b1;
      r_a       <= '0;
      r_d       <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bitcnt  <= w_bitcnt_nx;
      r_addr_sr <= w_addr_nx;
      r_data_sr <= w_data_nx;
      r_ovr     <= w_ovr_nx;
      r_frmcnt  <= w_frmcnt_nx;
      r_rw      <= w_rw_nx;
      r_a       <= w_a_nx;
      r_d       <= w_d_nx;
      r_err     <= w_err_nx;
      r_done    <= w_done_nx;
    end
  end

  assign RB2_RW    = r_rw;
  assign RB2_A     = r_a;
  assign RB2_D     = r_d;
  assign frame_err = r_err;
  assign done      = r_done;

endmodule

// File: tb/tb_s2_frame_receiver.sv
// Directed + randomized bench for s2_frame_receiver; a frame-level model predicts
// the write/err pulse and held RB2 values at every sampled cycle.
module tb_s2_frame_receiver;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 18;
  localparam int FRAMES = 8;
  localparam int TOT    = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              sen;
  logic              sd;
  logic              rb2_rw;
  logic [ADDR_W-1:0] rb2_a;
  logic [DATA_W-1:0] rb2_d;
  logic              frame_err;
  logic              done;

  int checks;
  int failures;

  // frame-level model state
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_d;
  logic              m_done;
  int                m_cnt;

  s2_frame_receiver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAMES(FRAMES)) dut (
    .clk      (clk),
    .rst      (rst),
    .sen      (sen),
    .sd       (sd),
    .RB2_RW   (rb2_rw),
    .RB2_A    (rb2_a),
    .RB2_D    (rb2_d),
    .frame_err(frame_err),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic exp_rw, input logic exp_err);
    chk({tag, ".rw"},   32'(rb2_rw),    32'(exp_rw));
    chk({tag, ".err"},  32'(frame_err), 32'(exp_err));
    chk({tag, ".a"},    32'(rb2_a),     32'(m_a));
    chk({tag, ".d"},    32'(rb2_d),     32'(m_d));
    chk({tag, ".done"}, 32'(done),      32'(m_done));
  endtask

  task automatic model_reset();
    m_a    = '0;
    m_d    = '0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  // Transmitter side: bits change on the falling edge, MSB first.
  task automatic send_bits(input string tag, input int nbits, input logic [31:0] val);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd  = val[nbits-1-i];
      @(posedge clk);
      #1;
      check_all({tag, ".bit"}, 1'b1, 1'b0);
    end
  endtask

  task automatic end_frame(input string tag, input int nbits, input logic [31:0] val, input int gap);
    logic exp_rw;
    logic exp_err;
    logic [31:0] v;
    exp_rw  = 1'b1;
    exp_err = 1'b0;
    v       = val;
    if (!m_done) begin
      if (nbits == TOT) begin
        m_a    = ADDR_W'(v >> DATA_W);
        m_d    = DATA_W'(v);
        m_cnt  = m_cnt + 1;
        m_done = (m_cnt == FRAMES);
        exp_rw = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      sen = 1'b1;
      sd  = 1'($urandom);
      @(posedge clk);
      #1;
      if (g == 0) check_all({tag, ".end"}, exp_rw, exp_err);
      else        check_all({tag, ".gap"}, 1'b1, 1'b0);
    end
  endtask

  task automatic send_frame(input string tag, input int nbits, input logic [31:0] val, input int gap);
    send_bits(tag, nbits, val);
    end_frame(tag, nbits, val, gap);
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ".rst"}, 1'b1, 1'b0);
    @(negedge clk);
    sen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ".post"}, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] val;
    int          r;
    int          nb;
    checks   = 0;
    failures = 0;
    sen      = 1'b1;
    sd       = 1'b0;
    rst      = 1'b1;
    model_reset();
    #1;
    check_all("reset", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("idle", 1'b1, 1'b0);

    // single frame, addr 5 data 2A5A5
    send_frame("single", TOT, (32'd5 << DATA_W) | 32'h2A5A5, 2);
    // short frame
    send_frame("short", 10, $urandom, 2);
    // overrun frame then good frame addr 2 data 1
    send_frame("overrun", 23, $urandom, 1);
    send_frame("after_ovr", TOT, (32'd2 << DATA_W) | 32'h00001, 2);

    // reset after 12 bits, then a good frame
    send_bits("midrst", 12, $urandom);
    do_reset("midrst");
    send_frame("post_rst", TOT, (32'd6 << DATA_W) | 32'h15555, 2);

    // randomized frames: mostly good, some short/overrun, random gaps
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      nb = TOT;
      else if (r < 8) nb = $urandom_range(1, TOT - 1);
      else            nb = $urandom_range(TOT + 1, TOT + 4);
      val = $urandom;
      send_frame("rand", nb, val, $urandom_range(1, 3));
    end

    // eight back-to-back frames after a clean reset
    @(negedge clk);
    do_reset("b2b");
    for (int a = 0; a < 8; a++) begin
      val = (32'(a) << DATA_W) | (32'(a) << 15) | 32'h7FFF;
      send_frame("b2b", TOT, val, 1);
    end
    chk("b2b.done_model", 32'(m_done), 32'd1);

    // frames after done are ignored
    send_frame("after_done", TOT, 32'h3FFFF, 2);
    send_frame("after_done_short", 5, $urandom, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
